// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receive-path and register-side signals of the UART RX FIFO
//   slave  : the FIFO (takes rx byte strobes and pop/clear, drives data/status)
//   master : the surrounding logic (UART receiver plus register interface)
interface uart_rx_fifo_if #(parameter int ADDR_W = 4);
  logic [7:0]    rx_data;
  logic          rx_data_valid;
  logic          rd_en;
  logic          overrun_clr;
  logic [7:0]    rd_data;
  logic          empty;
  logic          full;
  logic [ADDR_W:0] count;
  logic          overrun;
  logic          timeout;
  logic          irq;
  modport master (
    output rx_data, rx_data_valid, rd_en, overrun_clr,
    input  rd_data, empty, full, count, overrun, timeout, irq
  );
  modport slave (
    input  rx_data, rx_data_valid, rd_en, overrun_clr,
    output rd_data, empty, full, count, overrun, timeout, irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16550-style FWFT receive FIFO with level/overrun/timeout interrupt
//   clk, rst : clock and asynchronous active-high reset
//   bus      : rx_data/rx_data_valid byte strobe in, rd_en pop, overrun_clr;
//              rd_data head byte, empty/full/count, overrun, timeout, irq out
module uart_rx_fifo #(
  parameter int DEPTH          = 16,
  parameter int ADDR_W         = 4,
  parameter int TRIG_LEVEL     = 8,
  parameter int TIMEOUT_CYCLES = 11440,
  parameter int TIMEOUT_W      = 14
) (
  input logic            clk,
  input logic            rst,
  uart_rx_fifo_if.slave  bus
);
  localparam logic [TIMEOUT_W-1:0] TMAX = TIMEOUT_W'(TIMEOUT_CYCLES);
  logic [7:0]           r_mem [DEPTH];
  logic [ADDR_W-1:0]    r_rd_ptr, r_wr_ptr;
  logic [ADDR_W:0]      r_count;
  logic [TIMEOUT_W-1:0] r_tmr;
  logic                 r_vld_q, r_ovr, r_to;
  logic                 w_empty, w_full, w_push, w_pop, w_wr;
  logic [TIMEOUT_W-1:0] w_tmr_nxt;
  assign w_empty = r_count == '0;
  assign w_full  = r_count == (ADDR_W+1)'(DEPTH);
  // one capture per strobe: only the rising edge of rx_data_valid pushes
  assign w_push  = bus.rx_data_valid & ~r_vld_q;
  assign w_pop   = bus.rd_en & ~w_empty;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_tmr_nxt = (w_push | w_pop | w_empty) ? '0 :
                     (r_tmr == TMAX ? r_tmr : r_tmr + 1'b1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_tmr    <= '0;
      r_vld_q  <= 1'b1;
      r_ovr    <= 1'b0;
      r_to     <= 1'b0;
    end else begin
      r_vld_q <= bus.rx_data_valid;
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr != w_pop) r_count <= w_wr ? r_count + 1'b1 : r_count - 1'b1;
      r_ovr <= (w_push & w_full & ~w_pop) | (r_ovr & ~bus.overrun_clr);
      r_tmr <= w_tmr_nxt;
      r_to  <= w_tmr_nxt == TMAX;
    end
  end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr_ptr] <= bus.rx_data;
  assign bus.rd_data = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign bus.empty   = w_empty;
  assign bus.full    = w_full;
  assign bus.count   = r_count;
  assign bus.overrun = r_ovr;
  assign bus.timeout = r_to;
  assign bus.irq     = (r_count >= (ADDR_W+1)'(TRIG_LEVEL)) | r_to | r_ovr;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized and directed checks of uart_rx_fifo against a queue model
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int TRIG  = 8;
  localparam int TOUT  = 11440;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errs   = 0;
  int   cyc    = 0;
  logic [7:0] q [$];
  bit   m_ovr  = 1'b0;
  bit   m_vq   = 1'b1;
  int   m_last = 0;
  uart_rx_fifo_if #(.ADDR_W(4)) bus ();
  uart_rx_fifo #(
    .DEPTH(DEPTH), .ADDR_W(4), .TRIG_LEVEL(TRIG), .TIMEOUT_CYCLES(TOUT), .TIMEOUT_W(14)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  task automatic check_all();
    bit to;
    to = q.size() > 0 && (cyc - m_last) >= TOUT;
    chk("count", 32'(bus.count), 32'(q.size()));
    chk("empty", 32'(bus.empty), 32'(q.size() == 0));
    chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
    chk("rd_data", 32'(bus.rd_data), q.size() > 0 ? 32'(q[0]) : 32'h0);
    chk("overrun", 32'(bus.overrun), 32'(m_ovr));
    chk("timeout", 32'(bus.timeout), 32'(to));
    chk("irq", 32'(bus.irq), 32'(q.size() >= TRIG || to || m_ovr));
  endtask
  task automatic cycle();
    bit push, pop, was_empty, was_full, set;
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      m_ovr  = 1'b0;
      m_vq   = 1'b1;
      m_last = cyc;
    end else begin
      push = bus.rx_data_valid && !m_vq;
      pop = bus.rd_en && q.size() > 0;
      was_empty = q.size() == 0;
      was_full = q.size() == DEPTH;
      set = 1'b0;
      if (pop) void'(q.pop_front());
      if (push) begin
        if (!was_full || pop) q.push_back(bus.rx_data);
        else set = 1'b1;
      end
      m_ovr = set || (m_ovr && !bus.overrun_clr);
      if (push || pop || was_empty) m_last = cyc;
      m_vq = bus.rx_data_valid;
    end
    @(negedge clk);
    check_all();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask
  task automatic push_byte(input logic [7:0] d);
    bus.rx_data = d;
    bus.rx_data_valid = 1'b1;
    cycle();
    bus.rx_data_valid = 1'b0;
    cycle();
  endtask
  task automatic pop_byte();
    bus.rd_en = 1'b1;
    cycle();
    bus.rd_en = 1'b0;
  endtask
  initial begin
    bus.rx_data = 8'h00;
    bus.rx_data_valid = 1'b0;
    bus.rd_en = 1'b0;
    bus.overrun_clr = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(2);
    // single strobes spaced apart, then drain to empty
    push_byte(8'h41); idle(300);
    push_byte(8'h42); idle(300);
    push_byte(8'h43); idle(2);
    chk("t1_count", 32'(bus.count), 32'd3);
    chk("t1_head", 32'(bus.rd_data), 32'h41);
    for (int i = 0; i < 3; i++) begin
      chk("t1_pop", 32'(bus.rd_data), 32'h41 + 32'(i));
      pop_byte();
    end
    chk("t1_empty", 32'(bus.empty), 32'd1);
    chk("t1_rd0", 32'(bus.rd_data), 32'h0);
    // long strobe captures once
    bus.rx_data = 8'h5A;
    bus.rx_data_valid = 1'b1;
    idle(5);
    bus.rx_data_valid = 1'b0;
    idle(2);
    chk("t2_count", 32'(bus.count), 32'd1);
    pop_byte();
    // overflow by one
    for (int i = 0; i <= DEPTH; i++) push_byte(8'(i));
    chk("t3_full", 32'(bus.full), 32'd1);
    chk("t3_ovr", 32'(bus.overrun), 32'd1);
    chk("t3_irq", 32'(bus.irq), 32'd1);
    bus.rd_en = 1'b1;
    idle(DEPTH);
    bus.rd_en = 1'b0;
    cycle();
    bus.overrun_clr = 1'b1;
    cycle();
    bus.overrun_clr = 1'b0;
    chk("t3_clr", 32'(bus.overrun), 32'd0);
    // simultaneous push and pop while full
    for (int i = 0; i < DEPTH; i++) push_byte(8'h80 + 8'(i));
    bus.rx_data = 8'hEE;
    bus.rx_data_valid = 1'b1;
    bus.rd_en = 1'b1;
    cycle();
    bus.rx_data_valid = 1'b0;
    bus.rd_en = 1'b0;
    cycle();
    chk("t4_count", 32'(bus.count), 32'd16);
    chk("t4_ovr", 32'(bus.overrun), 32'd0);
    bus.rd_en = 1'b1;
    idle(DEPTH + 3);
    bus.rd_en = 1'b0;
    cycle();
    chk("t4_empty", 32'(bus.count), 32'd0);
    // trigger level
    for (int i = 0; i < TRIG - 1; i++) push_byte(8'h30 + 8'(i));
    chk("t5_below", 32'(bus.irq), 32'd0);
    push_byte(8'h3F);
    chk("t5_at", 32'(bus.irq), 32'd1);
    pop_byte();
    chk("t5_after_pop", 32'(bus.irq), 32'd0);
    bus.rd_en = 1'b1;
    idle(TRIG);
    bus.rd_en = 1'b0;
    cycle();
    // character timeout
    push_byte(8'h77);
    idle(TOUT + 4);
    chk("t6_to", 32'(bus.timeout), 32'd1);
    pop_byte();
    chk("t6_to_clr", 32'(bus.timeout), 32'd0);
    // reset mid-stream with a strobe held across release
    for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i));
    bus.rx_data = 8'h99;
    bus.rx_data_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_count", 32'(bus.count), 32'd0);
    chk("rst_async_empty", 32'(bus.empty), 32'd1);
    chk("rst_async_irq", 32'(bus.irq), 32'd0);
    cycle();
    cycle();
    rst = 1'b0;
    idle(4);
    bus.rx_data_valid = 1'b0;
    cycle();
    chk("rst_no_capture", 32'(bus.count), 32'd0);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bus.rx_data = 8'($urandom);
      bus.rx_data_valid = ($urandom_range(0, 99) < 45);
      bus.rd_en = ($urandom_range(0, 99) < 20);
      bus.overrun_clr = ($urandom_range(0, 99) < 4);
      cycle();
    end
    bus.rx_data_valid = 1'b0;
    bus.overrun_clr = 1'b0;
    bus.rd_en = 1'b1;
    idle(DEPTH + 2);
    bus.rd_en = 1'b0;
    cycle();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
